ac97_wb_fifo: RTL and testbench
===============================

AC97_WB_FIFO -- requirements
Module: ac97_wb_fifo

Interface
REQ-001 The block SHALL provide parameter DEPTH_LOG2, default 4, log2 of words per FIFO (16).
REQ-002 The block SHALL provide port clk_i  input  1  system clock; all logic on rising edge.
REQ-003 The block SHALL provide port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL provide port dat_i  input  32  Wishbone write data from AC97 DMA master (record samples).
REQ-005 The block SHALL provide port dat_o  output  32  Wishbone read data to AC97 DMA master (playback samples).
REQ-006 The block SHALL provide port adr_i  input  RAM_WB_ADR_WIDTH  Wishbone address, ignored (single streaming window).
REQ-007 The block SHALL provide ports we_i, cyc_i, stb_i  input  1 each  Wishbone write enable, cycle, strobe.
REQ-008 The block SHALL provide port cti_i  input  3  Wishbone cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
REQ-009 The block SHALL provide port ack_o  output  1  Wishbone acknowledge, registered.
REQ-010 The block SHALL provide ports rec_dout  output  32, rec_rd  input  1, rec_empty  output  1  host pop side of record FIFO.
REQ-011 The block SHALL provide ports play_din  input  32, play_wr  input  1, play_full  output  1  host push side of playback FIFO.
REQ-012 The block SHALL provide ports rec_level, play_level  output  DEPTH_LOG2+1 each  word counts; and underrun  output  1  sticky flag.

Function
REQ-013 The block SHALL contain two independent 2^DEPTH_LOG2 x 32 FIFOs (record, playback), each with read/write pointers one bit wider than the address for full/empty detection.
REQ-014 The block SHALL accept a write request (cyc_i&stb_i&we_i) only when the record FIFO is not full; it then pushes dat_i and asserts ack_o in the next cycle (1-cycle latency).
REQ-015 The block SHALL accept a read request (cyc_i&stb_i&!we_i) only when the playback FIFO is not empty; it then registers the head word onto dat_o, asserts ack_o next cycle and pops the word on that same edge.
REQ-016 While a request cannot be accepted the block SHALL hold ack_o low (wait states) and SHALL NOT push, pop or alter dat_o.
REQ-017 For cti_i = 000 or 111 the block SHALL drive ack_o for exactly one cycle and SHALL NOT re-accept until the cycle after that ack (one idle cycle between classic acks).
REQ-018 For cti_i = 010 the block SHALL accept on consecutive cycles, producing back-to-back acks while FIFO state allows.
REQ-019 If cyc_i or stb_i falls before acceptance the block SHALL abandon the request with no FIFO side effect.
REQ-020 Host rec_rd with rec_empty=1 and play_wr with play_full=1 SHALL be ignored; rec_dout SHALL show the record FIFO head combinationally (first-word-fall-through).
REQ-021 Full/empty/level SHALL be computed from registered pointers only; a simultaneous host pop on a full FIFO SHALL NOT enable a same-cycle Wishbone push (the push waits one cycle).
REQ-022 Simultaneous push and pop on the same FIFO in one cycle SHALL leave its level unchanged; pointers SHALL wrap modulo 2^(DEPTH_LOG2+1).
REQ-023 dat_o SHALL hold its last value when ack_o is low.

Reset
REQ-024 Assertion of rst_i SHALL immediately clear all pointers, ack_o, dat_o (0), underrun (0), and the accept-inhibit state; rec_empty=1, play_full=0, levels=0.
REQ-025 Reset asserted mid-burst or during a wait state SHALL terminate the access with no ack; FIFO contents are discarded.

Configuration
REQ-026 With macro AC97_FIFO_ZERO_FILL_EN defined, a read request on an empty playback FIFO SHALL be acked with 1-cycle latency, dat_o = 32'h0, no pop, and underrun set (sticky until reset).
REQ-027 Without AC97_FIFO_ZERO_FILL_EN, empty-read behaviour SHALL follow REQ-016 and underrun SHALL be tied to 0.

Verification
REQ-028 Classic write of 32'hA5A5_0001 to empty record FIFO -> ack_o high exactly one cycle later, rec_level=1, rec_dout=32'hA5A5_0001.
REQ-029 Host pushes 16 words 0..15, DMA burst read cti=010 for 16 words -> 16 back-to-back acks, dat_o sequence 0..15, play_level=0.
REQ-030 Fill record FIFO to 16, issue write -> ack held low; host rec_rd one cycle -> ack two cycles later, level returns to 16.
REQ-031 Empty playback, read request: without macro ack stays low for 20 cycles until play_wr of 32'h1234 then ack with dat_o=32'h1234; with macro ack next cycle, dat_o=0, underrun=1.
REQ-032 Assert rst_i during a 4-beat burst after beat 2 -> ack_o low same cycle, levels 0, rec_empty=1, underrun=0.

Source files
------------

// File: rtl/ac97_wb_fifo.sv
// rtl/ac97_wb_fifo.sv - AC97 DMA Wishbone slave bridging record/playback FIFOs.
// Optional AC97_FIFO_ZERO_FILL_EN: empty playback reads ack with zero data and set sticky underrun.
module ac97_wb_fifo #(
  parameter int DEPTH_LOG2       = 4,
  parameter int RAM_WB_ADR_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [31:0]                 dat_i,
  output logic [31:0]                 dat_o,
  input  logic [RAM_WB_ADR_WIDTH-1:0] adr_i,
  input  logic                        we_i,
  input  logic                        cyc_i,
  input  logic                        stb_i,
  input  logic [2:0]                  cti_i,
  output logic                        ack_o,
  output logic [31:0]                 rec_dout,
  input  logic                        rec_rd,
  output logic                        rec_empty,
  input  logic [31:0]                 play_din,
  input  logic                        play_wr,
  output logic                        play_full,
  output logic [DEPTH_LOG2:0]         rec_level,
  output logic [DEPTH_LOG2:0]         play_level,
  output logic                        underrun
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [31:0]   rec_mem  [DEPTH];
  logic [31:0]   play_mem [DEPTH];
  logic [PW-1:0] rec_wp_q, rec_rp_q, play_wp_q, play_rp_q;
  logic [PW-1:0] rec_wp_d, rec_rp_d, play_wp_d, play_rp_d;
  logic          ack_q, ack_d, inhibit_q, inhibit_d;
  logic [31:0]   dat_q, dat_d;
  logic          req, wb_wr, wb_rd, zero_rd, rec_pop, play_push;
  logic          rec_full, play_empty;
  logic          unused_adr;

  assign unused_adr = ^adr_i;

  assign rec_level  = rec_wp_q - rec_rp_q;
  assign play_level = play_wp_q - play_rp_q;
  assign rec_full   = (rec_level == PW'(DEPTH));
  assign rec_empty  = (rec_level == '0);
  assign play_full  = (play_level == PW'(DEPTH));
  assign play_empty = (play_level == '0);
  assign rec_dout   = rec_mem[rec_rp_q[DEPTH_LOG2-1:0]];
  assign ack_o      = ack_q;
  assign dat_o      = dat_q;

  always_comb begin
    // A classic ack blocks acceptance for the cycle in which it is visible.
    req       = cyc_i & stb_i & ~inhibit_q;
    wb_wr     = req & we_i & ~rec_full;
    wb_rd     = req & ~we_i & ~play_empty;
`ifdef AC97_FIFO_ZERO_FILL_EN
    zero_rd   = req & ~we_i & play_empty;
`else
    zero_rd   = 1'b0;
`endif
    rec_pop   = rec_rd & ~rec_empty;
    play_push = play_wr & ~play_full;
    ack_d     = wb_wr | wb_rd | zero_rd;
    inhibit_d = ack_d & (cti_i != 3'b010);
    dat_d     = dat_q;
    if (wb_rd)
      dat_d = play_mem[play_rp_q[DEPTH_LOG2-1:0]];
    else if (zero_rd)
      dat_d = 32'h0;
    rec_wp_d  = rec_wp_q + PW'(wb_wr);
    rec_rp_d  = rec_rp_q + PW'(rec_pop);
    play_wp_d = play_wp_q + PW'(play_push);
    play_rp_d = play_rp_q + PW'(wb_rd);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rec_wp_q  <= '0;
      rec_rp_q  <= '0;
      play_wp_q <= '0;
      play_rp_q <= '0;
      ack_q     <= 1'b0;
      inhibit_q <= 1'b0;
      dat_q     <= 32'h0;
    end else begin
      rec_wp_q  <= rec_wp_d;
      rec_rp_q  <= rec_rp_d;
      play_wp_q <= play_wp_d;
      play_rp_q <= play_rp_d;
      ack_q     <= ack_d;
      inhibit_q <= inhibit_d;
      dat_q     <= dat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wb_wr)
      rec_mem[rec_wp_q[DEPTH_LOG2-1:0]] <= dat_i;
    if (play_push)
      play_mem[play_wp_q[DEPTH_LOG2-1:0]] <= play_din;
  end

`ifdef AC97_FIFO_ZERO_FILL_EN
  logic underrun_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      underrun_q <= 1'b0;
    else if (zero_rd)
      underrun_q <= 1'b1;
  end
  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_ac97_wb_fifo.sv
// tb/tb_ac97_wb_fifo.sv - directed self-checking bench for ac97_wb_fifo.
module tb_ac97_wb_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] dat_i, dat_o, rec_dout, play_din;
  logic [31:0] adr_i;
  logic        we_i, cyc_i, stb_i, ack_o;
  logic [2:0]  cti_i;
  logic        rec_rd, rec_empty, play_wr, play_full, underrun;
  logic [4:0]  rec_level, play_level;

  int n_cmp = 0;
  int n_err = 0;

  ac97_wb_fifo #(.DEPTH_LOG2(4), .RAM_WB_ADR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .dat_o(dat_o), .adr_i(adr_i),
    .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .cti_i(cti_i), .ack_o(ack_o),
    .rec_dout(rec_dout), .rec_rd(rec_rd), .rec_empty(rec_empty),
    .play_din(play_din), .play_wr(play_wr), .play_full(play_full),
    .rec_level(rec_level), .play_level(play_level), .underrun(underrun)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb_req(input logic we, input logic [2:0] cti, input logic [31:0] d);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; cti_i = cti; dat_i = d;
  endtask

  task automatic wb_idle;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cti_i = 3'b000;
  endtask

  initial begin
    rst_i = 1'b1; dat_i = '0; adr_i = '0; rec_rd = 1'b0; play_wr = 1'b0; play_din = '0;
    wb_idle();
    tick(); tick();
    check("rst_ack", 32'(ack_o), 0);
    check("rst_dat", dat_o, 0);
    check("rst_rec_empty", 32'(rec_empty), 1);
    check("rst_play_full", 32'(play_full), 0);
    check("rst_rec_level", 32'(rec_level), 0);
    check("rst_play_level", 32'(play_level), 0);
    check("rst_underrun", 32'(underrun), 0);
    rst_i = 1'b0;
    tick();

    // Classic write held for three edges: ack, inhibit, ack.
    wb_req(1'b1, 3'b000, 32'hA5A5_0001);
    tick();
    check("cl_ack1", 32'(ack_o), 1);
    check("cl_level1", 32'(rec_level), 1);
    check("cl_dout", rec_dout, 32'hA5A5_0001);
    dat_i = 32'hA5A5_0002;
    tick();
    check("cl_gap", 32'(ack_o), 0);
    tick();
    check("cl_ack2", 32'(ack_o), 1);
    check("cl_level2", 32'(rec_level), 2);
    wb_idle();
    tick();
    check("cl_ack_off", 32'(ack_o), 0);
    rec_rd = 1'b1;
    tick();
    check("cl_pop_head", rec_dout, 32'hA5A5_0002);
    tick();
    rec_rd = 1'b0;
    check("cl_empty", 32'(rec_empty), 1);

    // Playback fill, overflow attempt, 16-beat burst read.
    play_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      play_din = i;
      tick();
    end
    check("pl_full", 32'(play_full), 1);
    play_din = 32'd99;
    tick();
    play_wr = 1'b0;
    check("pl_level_ovf", 32'(play_level), 16);
    for (int i = 0; i < 16; i++) begin
      wb_req(1'b0, (i == 15) ? 3'b111 : 3'b010, 32'h0);
      tick();
      check($sformatf("br_ack%0d", i), 32'(ack_o), 1);
      check($sformatf("br_dat%0d", i), dat_o, i);
    end
    wb_idle();
    check("br_level", 32'(play_level), 0);
    tick();
    check("br_ack_off", 32'(ack_o), 0);
    check("br_dat_hold", dat_o, 15);

    // Record fill by burst, then wait states while full.
    for (int i = 0; i < 16; i++) begin
      wb_req(1'b1, 3'b010, 32'd100 + i);
      tick();
    end
    check("rf_level", 32'(rec_level), 16);
    wb_req(1'b1, 3'b000, 32'd200);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rf_wait%0d", i), 32'(ack_o), 0);
    end
    check("rf_level_wait", 32'(rec_level), 16);
    rec_rd = 1'b1;
    tick();
    rec_rd = 1'b0;
    check("rf_ack_pop", 32'(ack_o), 0);
    check("rf_level_pop", 32'(rec_level), 15);
    tick();
    check("rf_ack_late", 32'(ack_o), 1);
    check("rf_level_back", 32'(rec_level), 16);
    wb_idle();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("rf_drain%0d", i), rec_dout, (i < 15) ? 32'd101 + i : 32'd200);
      rec_rd = 1'b1;
      tick();
    end
    tick();
    rec_rd = 1'b0;
    check("rf_empty_rd", 32'(rec_level), 0);

    // Read request against empty playback FIFO.
    wb_req(1'b0, 3'b000, 32'h0);
`ifdef AC97_FIFO_ZERO_FILL_EN
    tick();
    check("zf_ack", 32'(ack_o), 1);
    check("zf_dat", dat_o, 0);
    check("zf_underrun", 32'(underrun), 1);
    wb_idle();
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("ur_wait%0d", i), 32'(ack_o), 0);
    end
    check("ur_dat_hold", dat_o, 15);
    play_wr = 1'b1; play_din = 32'h1234;
    tick();
    play_wr = 1'b0;
    check("ur_ack_push", 32'(ack_o), 0);
    tick();
    check("ur_ack", 32'(ack_o), 1);
    check("ur_dat", dat_o, 32'h1234);
    wb_idle();
    check("ur_underrun", 32'(underrun), 0);
    tick();
`endif
    check("ur_play_level", 32'(play_level), 0);

    // Reset mid-burst after two beats.
    for (int i = 0; i < 2; i++) begin
      wb_req(1'b1, 3'b010, 32'd300 + i);
      tick();
      check($sformatf("rb_ack%0d", i), 32'(ack_o), 1);
    end
    rst_i = 1'b1;
    #1;
    check("rb_ack", 32'(ack_o), 0);
    check("rb_rec_level", 32'(rec_level), 0);
    check("rb_rec_empty", 32'(rec_empty), 1);
    check("rb_play_level", 32'(play_level), 0);
    check("rb_underrun", 32'(underrun), 0);
    check("rb_dat", dat_o, 0);
    wb_idle();
    tick();
    rst_i = 1'b0;
    tick();
    check("rb_ack_after", 32'(ack_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
